// File: rtl/simon_sequencer.sv
// rtl/simon_sequencer.sv - memory-game round controller: request, store, play back and check symbols.
// Optional player idle timeout in INPUT is enabled by defining SEQ_TIMEOUT_EN.
module simon_sequencer #(
    parameter int MAX_LEN        = 16,
    parameter int RAND_LAT       = 2,
    parameter int ON_CYCLES      = 8,
    parameter int OFF_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    output logic                         rand_req,
    input  logic [1:0]                   rand_val,
    input  logic                         btn_valid,
    input  logic [1:0]                   btn_code,
    output logic                         show_valid,
    output logic [1:0]                   show_code,
    output logic [$clog2(MAX_LEN+1)-1:0] round,
    output logic                         busy,
    output logic                         win,
    output logic                         fail
);
    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int RW   = $clog2(MAX_LEN + 1);
    localparam int IW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int CMAX = imax(imax(RAND_LAT, ON_CYCLES), imax(OFF_CYCLES, TIMEOUT_CYCLES));
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_PLAY_ON, S_PLAY_OFF, S_INPUT, S_WIN, S_FAIL
    } state_t;

    state_t          state;
    logic [RW-1:0]   len;
    logic [IW-1:0]   idx;
    logic [CW-1:0]   cnt;
    logic [1:0]      mem [MAX_LEN];

    logic [1:0]      sym;
    logic [IW-1:0]   idx_next;
    logic            last_idx;
    logic            wait_done;

    assign sym       = (rand_val == 2'd3) ? 2'd0 : rand_val;
    assign idx_next  = idx + IW'(1);
    assign last_idx  = (RW'(idx) == len - RW'(1));
    assign wait_done = (state == S_WAIT) && (cnt == CW'(RAND_LAT - 1));
    assign round     = len;

    // Symbol storage needs no reset; only written positions are ever read.
    always_ff @(posedge clk) begin
        if (wait_done) begin
            mem[len[IW-1:0]] <= sym;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            len        <= '0;
            idx        <= '0;
            cnt        <= '0;
            rand_req   <= 1'b0;
            show_valid <= 1'b0;
            show_code  <= 2'd0;
            busy       <= 1'b0;
            win        <= 1'b0;
            fail       <= 1'b0;
        end else begin
            rand_req <= 1'b0;
            cnt      <= cnt + CW'(1);
            case (state)
                S_IDLE, S_WIN, S_FAIL: begin
                    if (start) begin
                        len      <= '0;
                        idx      <= '0;
                        win      <= 1'b0;
                        fail     <= 1'b0;
                        busy     <= 1'b1;
                        rand_req <= 1'b1;
                        cnt      <= '0;
                        state    <= S_REQ;
                    end
                end
                // Entered from IDLE the pulse is already up; entered from INPUT it is raised here.
                S_REQ: begin
                    cnt <= '0;
                    if (rand_req) begin
                        state <= S_WAIT;
                    end else begin
                        rand_req <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (cnt == CW'(RAND_LAT - 1)) begin
                        len        <= len + RW'(1);
                        idx        <= '0;
                        cnt        <= '0;
                        show_valid <= 1'b1;
                        show_code  <= (len == '0) ? sym : mem[0];
                        state      <= S_PLAY_ON;
                    end
                end
                S_PLAY_ON: begin
                    if (cnt == CW'(ON_CYCLES - 1)) begin
                        cnt        <= '0;
                        show_valid <= 1'b0;
                        show_code  <= 2'd0;
                        state      <= S_PLAY_OFF;
                    end
                end
                S_PLAY_OFF: begin
                    if (cnt == CW'(OFF_CYCLES - 1)) begin
                        cnt <= '0;
                        if (last_idx) begin
                            idx   <= '0;
                            state <= S_INPUT;
                        end else begin
                            idx        <= idx_next;
                            show_valid <= 1'b1;
                            show_code  <= mem[idx_next];
                            state      <= S_PLAY_ON;
                        end
                    end
                end
                S_INPUT: begin
                    if (btn_valid) begin
                        cnt <= '0;
                        if (btn_code != mem[idx]) begin
                            fail  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_FAIL;
                        end else if (!last_idx) begin
                            idx <= idx_next;
                        end else if (len == RW'(MAX_LEN)) begin
                            win   <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_WIN;
                        end else begin
                            state <= S_REQ;
                        end
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        fail  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_FAIL;
                    end
`else
`endif
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
